// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and
// data (LW/SW) access. Data wins by default. Fetch is forced through after
// STARVE_MAX back-to-back data grants while it waits. HLT parks the block
// until reset.
// Optional macro MEM_TIMEOUT_EN: a transaction that sees no mem_ack within
// TIMEOUT cycles is aborted, returns rdata = 0 and pulses mem_err.
module mem_port_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_valid,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_valid,
    output logic [DATA_W-1:0] rdata,
    input  logic              halt,
    output logic              stall,
    output logic              busy,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
`ifdef MEM_TIMEOUT_EN
    ,
    output logic              mem_err
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DATA, S_HALTED} state_t;

    localparam int            SC_W   = 4;
    localparam logic [SC_W-1:0] SC_MAX = SC_W'(STARVE_MAX);

    // Reject configurations the starve counter or timeout cannot represent.
    if (STARVE_MAX < 1 || STARVE_MAX > 15 || TIMEOUT < 1) begin : g_bad_cfg
        $error("mem_port_arbiter: STARVE_MAX must be 1..15, TIMEOUT >= 1");
    end

    state_t              r_state;
    logic [SC_W-1:0]     r_starve;
    logic                r_if_gnt, r_d_gnt, r_if_valid, r_d_valid;
    logic                r_busy, r_mem_en, r_mem_wr;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata, r_rdata;

    logic w_starved, w_take_fetch, w_take_data, w_go_halt, w_timeout;

    // IDLE arbitration: a starved fetch beats data, data beats halt,
    // halt beats an ordinary fetch.
    assign w_starved    = if_req && (r_starve == SC_MAX);
    assign w_take_fetch = w_starved || (if_req && !d_req && !halt);
    assign w_take_data  = !w_starved && d_req;
    assign w_go_halt    = !w_starved && !d_req && halt;

`ifdef MEM_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] r_to_cnt;
    logic            r_mem_err;
    assign w_timeout = !mem_ack && (r_to_cnt == TO_W'(TIMEOUT - 1));
    assign mem_err   = r_mem_err;
`else
    assign w_timeout = 1'b0;
`endif

    // Port sequencer: arbitrate in IDLE, hold the port until ack, then
    // return data and pulse the requester's valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_starve    <= '0;
            r_if_gnt    <= 1'b0;
            r_d_gnt     <= 1'b0;
            r_if_valid  <= 1'b0;
            r_d_valid   <= 1'b0;
            r_busy      <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rdata     <= '0;
`ifdef MEM_TIMEOUT_EN
            r_to_cnt    <= '0;
            r_mem_err   <= 1'b0;
`endif
        end else begin
            r_if_gnt   <= 1'b0;
            r_d_gnt    <= 1'b0;
            r_if_valid <= 1'b0;
            r_d_valid  <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            r_mem_err  <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (!if_req) r_starve <= '0;
`ifdef MEM_TIMEOUT_EN
                    r_to_cnt <= '0;
`endif
                    if (w_take_fetch) begin
                        r_state    <= S_FETCH;
                        r_if_gnt   <= 1'b1;
                        r_busy     <= 1'b1;
                        r_mem_en   <= 1'b1;
                        r_mem_wr   <= 1'b0;
                        r_mem_addr <= if_addr;
                        r_starve   <= '0;
                    end else if (w_take_data) begin
                        r_state     <= S_DATA;
                        r_d_gnt     <= 1'b1;
                        r_busy      <= 1'b1;
                        r_mem_en    <= 1'b1;
                        r_mem_wr    <= d_wr;
                        r_mem_addr  <= d_addr;
                        r_mem_wdata <= d_wdata;
                        if (if_req && r_starve != SC_MAX)
                            r_starve <= r_starve + SC_W'(1);
                    end else if (w_go_halt) begin
                        r_state <= S_HALTED;
                    end
                end
                S_FETCH, S_DATA: begin
`ifdef MEM_TIMEOUT_EN
                    r_to_cnt <= r_to_cnt + TO_W'(1);
`endif
                    if (mem_ack || w_timeout) begin
                        r_state  <= S_IDLE;
                        r_busy   <= 1'b0;
                        r_mem_en <= 1'b0;
                        r_mem_wr <= 1'b0;
                        // stores leave the last read data in place
                        if (w_timeout)     r_rdata <= '0;
                        else if (!r_mem_wr) r_rdata <= mem_rdata;
                        if (r_state == S_FETCH) r_if_valid <= 1'b1;
                        else                    r_d_valid  <= 1'b1;
`ifdef MEM_TIMEOUT_EN
                        r_mem_err <= w_timeout;
`endif
                    end
                end
                default: ;  // S_HALTED: parked until reset
            endcase
        end
    end

    assign if_gnt    = r_if_gnt;
    assign d_gnt     = r_d_gnt;
    assign if_valid  = r_if_valid;
    assign d_valid   = r_d_valid;
    assign busy      = r_busy;
    assign mem_en    = r_mem_en;
    assign mem_wr    = r_mem_wr;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign rdata     = r_rdata;
    assign stall     = d_req && !r_d_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: reset values, a directed vector table,
// starvation / halt / async-reset sequences and randomized traffic checked
// against a transaction-level reference model.
module tb_mem_port_arbiter;
  localparam int STARVE_MAX = 4;
`ifdef MEM_TIMEOUT_EN
  localparam int TB_TIMEOUT = 8;
`else
  localparam int TB_TIMEOUT = 64;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, d_req, d_wr, halt, mem_ack;
  logic [15:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic        if_gnt, if_valid, d_gnt, d_valid, stall, busy, mem_en, mem_wr;
  logic [15:0] rdata, mem_addr, mem_wdata;
`ifdef MEM_TIMEOUT_EN
  logic        mem_err;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .STARVE_MAX(STARVE_MAX), .TIMEOUT(TB_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_valid(d_valid), .rdata(rdata), .halt(halt),
    .stall(stall), .busy(busy), .mem_en(mem_en), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
`ifdef MEM_TIMEOUT_EN
    , .mem_err(mem_err)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // {if_gnt, d_gnt, if_valid, d_valid, mem_en, mem_wr, busy, stall}
  function automatic logic [7:0] flags();
    return {if_gnt, d_gnt, if_valid, d_valid, mem_en, mem_wr, busy, stall};
  endfunction

  // ---------------- reference model (transaction level) ----------------
  bit          m_busy, m_fetch, m_wr, m_halted;
  logic [15:0] m_addr, m_wdata, m_rdata;
  int          m_starve;
  bit          e_if_gnt, e_d_gnt, e_if_valid, e_d_valid;

  task automatic model_reset();
    m_busy = 0; m_fetch = 0; m_wr = 0; m_halted = 0;
    m_addr = '0; m_wdata = '0; m_rdata = '0; m_starve = 0;
    e_if_gnt = 0; e_d_gnt = 0; e_if_valid = 0; e_d_valid = 0;
  endtask

  // Advance the model across one clock edge using the inputs now applied.
  task automatic model_step();
    bit starved;
    e_if_gnt = 0; e_d_gnt = 0; e_if_valid = 0; e_d_valid = 0;
    if (m_halted) return;
    if (m_busy) begin
      if (mem_ack) begin
        m_busy = 0;
        if (!m_wr) m_rdata = mem_rdata;
        if (m_fetch) e_if_valid = 1; else e_d_valid = 1;
      end
    end else begin
      starved = if_req && (m_starve >= STARVE_MAX);
      if (starved || (if_req && !d_req && !halt)) begin
        m_busy = 1; m_fetch = 1; m_wr = 0; m_addr = if_addr;
        m_starve = 0; e_if_gnt = 1;
      end else if (d_req) begin
        m_busy = 1; m_fetch = 0; m_wr = d_wr; m_addr = d_addr; m_wdata = d_wdata;
        e_d_gnt = 1;
        m_starve = if_req ? ((m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX) : 0;
      end else begin
        m_starve = 0;
        if (halt) m_halted = 1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".flags"}, 32'(flags()),
        32'({e_if_gnt, e_d_gnt, e_if_valid, e_d_valid, m_busy, m_busy & m_wr, m_busy,
             d_req & ~e_d_valid}));
    chk({tag, ".rdata"}, 32'(rdata), 32'(m_rdata));
    if (m_busy) chk({tag, ".mem_addr"}, 32'(mem_addr), 32'(m_addr));
    if (m_busy && m_wr) chk({tag, ".mem_wdata"}, 32'(mem_wdata), 32'(m_wdata));
`ifdef MEM_TIMEOUT_EN
    chk({tag, ".mem_err"}, 32'(mem_err), 32'(0));
`endif
  endtask

  // Inputs are applied at the falling edge; the model and DUT both take
  // the rising edge, and outputs are compared at the next falling edge.
  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic clear_inputs();
    if_req = 0; d_req = 0; d_wr = 0; halt = 0; mem_ack = 0;
    if_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    clear_inputs();
    @(negedge clk);
    rst_n = 1;
    model_reset();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [3:0]  ctl;      // {if_req, d_req, d_wr, mem_ack}
    logic [15:0] if_addr, d_addr, d_wdata, mrd;
    logic [7:0]  xo;       // expected flags()
    logic [15:0] x_rdata, x_addr, x_wdata;
  } vec_t;

  vec_t tv[17];
  int   gseq[$];
  int   exp_seq[10];
  int   n_gnt, n_en, bc;
  bit   d_got;

  initial begin
    tv[0]  = '{4'b1000, 16'h0010, 16'h0000, 16'h0000, 16'h0000, 8'b1000_1010, 16'h0000, 16'h0010, 16'h0000};
    tv[1]  = '{4'b0001, 16'h0000, 16'h0000, 16'h0000, 16'hA123, 8'b0010_0000, 16'hA123, 16'h0000, 16'h0000};
    tv[2]  = '{4'b0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 8'b0000_0000, 16'hA123, 16'h0000, 16'h0000};
    tv[3]  = '{4'b1100, 16'h0012, 16'h0200, 16'h0000, 16'h0000, 8'b0100_1011, 16'hA123, 16'h0200, 16'h0000};
    tv[4]  = '{4'b1101, 16'h0012, 16'h0200, 16'h0000, 16'hBEEF, 8'b0001_0000, 16'hBEEF, 16'h0000, 16'h0000};
    tv[5]  = '{4'b1000, 16'h0012, 16'h0000, 16'h0000, 16'h0000, 8'b1000_1010, 16'hBEEF, 16'h0012, 16'h0000};
    tv[6]  = '{4'b0001, 16'h0000, 16'h0000, 16'h0000, 16'h1111, 8'b0010_0000, 16'h1111, 16'h0000, 16'h0000};
    tv[7]  = '{4'b0110, 16'h0000, 16'h0300, 16'h5A5A, 16'h0000, 8'b0100_1111, 16'h1111, 16'h0300, 16'h5A5A};
    tv[8]  = '{4'b0110, 16'h0000, 16'h0300, 16'h5A5A, 16'h0000, 8'b0000_1111, 16'h1111, 16'h0300, 16'h5A5A};
    tv[9]  = '{4'b0110, 16'h0000, 16'h0300, 16'h5A5A, 16'h0000, 8'b0000_1111, 16'h1111, 16'h0300, 16'h5A5A};
    tv[10] = '{4'b0110, 16'h0000, 16'h0300, 16'h5A5A, 16'h0000, 8'b0000_1111, 16'h1111, 16'h0300, 16'h5A5A};
    tv[11] = '{4'b0111, 16'h0000, 16'h0300, 16'h5A5A, 16'hFFFF, 8'b0001_0000, 16'h1111, 16'h0000, 16'h0000};
    tv[12] = '{4'b0001, 16'h0000, 16'h0000, 16'h0000, 16'h7777, 8'b0000_0000, 16'h1111, 16'h0000, 16'h0000};
    tv[13] = '{4'b1101, 16'h0020, 16'h0400, 16'h0000, 16'h3333, 8'b0100_1011, 16'h1111, 16'h0400, 16'h0000};
    tv[14] = '{4'b1101, 16'h0020, 16'h0400, 16'h0000, 16'h4444, 8'b0001_0000, 16'h4444, 16'h0000, 16'h0000};
    tv[15] = '{4'b1000, 16'h0020, 16'h0000, 16'h0000, 16'h0000, 8'b1000_1010, 16'h4444, 16'h0020, 16'h0000};
    tv[16] = '{4'b0001, 16'h0000, 16'h0000, 16'h0000, 16'h5555, 8'b0010_0000, 16'h5555, 16'h0000, 16'h0000};

    // reset state, with a request already pending
    clear_inputs();
    rst_n = 0;
    if_req = 1;
    @(negedge clk);
    @(negedge clk);
    chk("reset.flags", 32'(flags()), 32'(0));
    chk("reset.rdata", 32'(rdata), 32'(0));
    chk("reset.mem_addr", 32'(mem_addr), 32'(0));
    chk("reset.mem_wdata", 32'(mem_wdata), 32'(0));
    clear_inputs();
    rst_n = 1;

    foreach (tv[i]) begin
      {if_req, d_req, d_wr, mem_ack} = tv[i].ctl;
      if_addr = tv[i].if_addr; d_addr = tv[i].d_addr;
      d_wdata = tv[i].d_wdata; mem_rdata = tv[i].mrd;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d.flags", i), 32'(flags()), 32'(tv[i].xo));
      chk($sformatf("vec%0d.rdata", i), 32'(rdata), 32'(tv[i].x_rdata));
      if (tv[i].xo[3]) chk($sformatf("vec%0d.mem_addr", i), 32'(mem_addr), 32'(tv[i].x_addr));
      if (tv[i].xo[3] && tv[i].xo[2])
        chk($sformatf("vec%0d.mem_wdata", i), 32'(mem_wdata), 32'(tv[i].x_wdata));
    end

    // starvation: both requesters hold continuously, memory acks at once
    do_reset();
    exp_seq = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1};
    if_req = 1; if_addr = 16'h0070;
    d_req = 1; d_wr = 0; d_addr = 16'h0600;
    for (int c = 0; c < 20; c++) begin
      mem_ack = m_busy;
      mem_rdata = 16'($urandom);
      tick("starve");
      if (if_gnt) gseq.push_back(1);
      else if (d_gnt) gseq.push_back(2);
    end
    chk("starve.count", 32'(gseq.size()), 32'(10));
    for (int i = 0; i < 10 && i < gseq.size(); i++)
      chk($sformatf("starve.grant%0d", i), 32'(gseq[i]), 32'(exp_seq[i]));

    // halt raised mid-DATA: load completes, then the block parks
    do_reset();
    d_req = 1; d_wr = 0; d_addr = 16'h0500;
    tick("halt.acc");
    halt = 1;
    tick("halt.wait");
    mem_ack = 1; mem_rdata = 16'h9999;
    tick("halt.ack");
    chk("halt.d_valid", 32'(d_valid), 32'(1));
    d_req = 0; mem_ack = 0; if_req = 1; if_addr = 16'h0060;
    n_gnt = 0; n_en = 0;
    for (int c = 0; c < 6; c++) begin
      if (c == 3) d_req = 1;
      mem_ack = (c == 4);
      tick("halted");
      n_gnt += int'(if_gnt) + int'(d_gnt);
      n_en  += int'(mem_en);
    end
    chk("halted.grants", 32'(n_gnt), 32'(0));
    chk("halted.mem_en", 32'(n_en), 32'(0));
    chk("halted.stall", 32'(stall), 32'(1));

    // reset asserted in the middle of a fetch clears everything at once
    do_reset();
    if_req = 1; if_addr = 16'h0041;
    tick("arst.f1");
    if_req = 0; mem_ack = 1; mem_rdata = 16'h6666;
    tick("arst.f1ack");
    mem_ack = 0; if_req = 1; if_addr = 16'h0042;
    tick("arst.f2");
    if_req = 0;
    tick("arst.f2wait");
    #2 rst_n = 0;
    #1;
    chk("arst.flags", 32'(flags()), 32'(0));
    chk("arst.rdata", 32'(rdata), 32'(0));
    chk("arst.mem_addr", 32'(mem_addr), 32'(0));
    mem_ack = 1;
    @(posedge clk);
    @(negedge clk);
    chk("arst.no_valid", 32'(flags()), 32'(0));
    rst_n = 1;
    clear_inputs();
    model_reset();

    // randomized traffic against the model
    do_reset();
    d_got = 0; bc = 0;
    for (int c = 0; c < 1500; c++) begin
      if (if_req) begin
        if (e_if_gnt) if_req = 0;
      end else if ($urandom_range(2) == 0) begin
        if_req = 1; if_addr = 16'($urandom);
      end
      if (e_d_gnt) d_got = 1;
      if (d_req) begin
        if (d_got && $urandom_range(1) == 0) d_req = 0;
      end else if ($urandom_range(2) == 0) begin
        d_req = 1; d_got = 0;
        d_wr = 1'($urandom_range(1));
        d_addr = 16'($urandom); d_wdata = 16'($urandom);
      end
      bc = m_busy ? bc + 1 : 0;
      mem_ack = (bc >= 4) || ($urandom_range(2) == 0);
      mem_rdata = 16'($urandom);
      tick($sformatf("rnd%0d", c));
    end

`ifdef MEM_TIMEOUT_EN
    // no ack for TIMEOUT cycles: abort with rdata 0 and mem_err
    do_reset();
    if_req = 1; if_addr = 16'h0080;
    @(posedge clk); @(negedge clk);
    if_req = 0; mem_ack = 1; mem_rdata = 16'hCAFE;
    @(posedge clk); @(negedge clk);
    chk("to.first_rdata", 32'(rdata), 32'(16'hCAFE));
    mem_ack = 0; if_req = 1; if_addr = 16'h0090;
    @(posedge clk); @(negedge clk);
    chk("to.gnt", 32'(if_gnt), 32'(1));
    if_req = 0;
    for (int c = 0; c < TB_TIMEOUT - 1; c++) begin
      @(posedge clk); @(negedge clk);
      chk($sformatf("to.wait%0d", c), 32'({mem_en, if_valid, mem_err}), 32'(3'b100));
    end
    @(posedge clk); @(negedge clk);
    chk("to.abort", 32'({if_valid, mem_err, mem_en, busy}), 32'(4'b1100));
    chk("to.rdata", 32'(rdata), 32'(0));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
